// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//   Owns the call/branch-target stack and shares it between the datapath
//   (push/pop) and the program counter (pop only). One transaction is in
//   flight at a time: IDLE grants, EXEC performs the stack operation, DONE
//   reports completion. When both requesters are active the one that was not
//   granted last wins, so the two requesters alternate.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   dp_req/op/wdata        datapath request, 1 = push / 0 = pop, push data
//   dp_gnt/valid/rdata     datapath grant pulse, completion pulse, pop data
//   pc_req                 program-counter pop request
//   pc_gnt/valid/rdata     PC grant pulse, completion pulse, popped target
//   err_clr                synchronous clear of both sticky error flags
//   sp, empty, full        occupancy and its status decodes
//   ovf_err, unf_err       sticky push-while-full / pop-while-empty flags
// -----------------------------------------------------------------------------
module stack_arbiter #(
    parameter  int DATA_LEN  = 8,
    parameter  int STK_DEPTH = 16,
    localparam int SP_W      = $clog2(STK_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                dp_req,
    input  logic                dp_op,
    input  logic [DATA_LEN-1:0] dp_wdata,
    output logic                dp_gnt,
    output logic                dp_valid,
    output logic [DATA_LEN-1:0] dp_rdata,
    input  logic                pc_req,
    output logic                pc_gnt,
    output logic                pc_valid,
    output logic [DATA_LEN-1:0] pc_rdata,
    input  logic                err_clr,
    output logic [SP_W-1:0]     sp,
    output logic                empty,
    output logic                full,
    output logic                ovf_err,
    output logic                unf_err
);

    localparam int              AW      = $clog2(STK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STK_DEPTH);
    localparam logic            OWN_DP  = 1'b0;
    localparam logic            OWN_PC  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  grant_dp_s;
    logic                  grant_pc_s;
    // owner_r doubles as last_owner: it keeps the most recent grantee
    // until the next grant, which is exactly what round-robin needs.
    logic                  owner_r;
    logic                  op_r;
    logic [DATA_LEN-1:0]   wdata_r;
    logic [SP_W-1:0]       sp_r;
    logic                  dp_gnt_r;
    logic                  pc_gnt_r;
    logic                  dp_valid_r;
    logic                  pc_valid_r;
    logic [DATA_LEN-1:0]   dp_rdata_r;
    logic [DATA_LEN-1:0]   pc_rdata_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic [DATA_LEN-1:0]   mem_r [STK_DEPTH];

    logic                  empty_s;
    logic                  full_s;
    logic                  exec_s;
    logic                  do_push_s;
    logic                  do_pop_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic [AW-1:0]         rd_idx_s;
    logic [DATA_LEN-1:0]   pop_data_s;

    assign empty_s   = (sp_r == SP_ZERO);
    assign full_s    = (sp_r == SP_FULL);
    assign exec_s    = (state_r == ST_EXEC);
    assign do_push_s = exec_s &&  op_r && !full_s;
    assign ovf_set_s = exec_s &&  op_r &&  full_s;
    assign do_pop_s  = exec_s && !op_r && !empty_s;
    assign unf_set_s = exec_s && !op_r &&  empty_s;
    // Low bits only: at sp == STK_DEPTH they are zero and wrap to the top slot.
    assign rd_idx_s  = sp_r[AW-1:0] - AW'(1);
    assign pop_data_s = do_pop_s ? mem_r[rd_idx_s] : {DATA_LEN{1'b0}};

    // Next-state and grant decision.
    always_comb begin
        state_s    = state_r;
        grant_dp_s = 1'b0;
        grant_pc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pc_req && dp_req) begin
                    if (owner_r == OWN_DP) begin
                        grant_pc_s = 1'b1;
                    end else begin
                        grant_dp_s = 1'b1;
                    end
                end else if (pc_req) begin
                    grant_pc_s = 1'b1;
                end else if (dp_req) begin
                    grant_dp_s = 1'b1;
                end else begin
                    grant_pc_s = 1'b0;
                end
                if (grant_pc_s || grant_dp_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, grant/valid pulses and the latched transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_DP;
            op_r       <= 1'b0;
            wdata_r    <= {DATA_LEN{1'b0}};
            dp_gnt_r   <= 1'b0;
            pc_gnt_r   <= 1'b0;
            dp_valid_r <= 1'b0;
            pc_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            dp_gnt_r   <= grant_dp_s;
            pc_gnt_r   <= grant_pc_s;
            dp_valid_r <= (state_r == ST_DONE) && (owner_r == OWN_DP);
            pc_valid_r <= (state_r == ST_DONE) && (owner_r == OWN_PC);
            if (grant_pc_s) begin
                owner_r <= OWN_PC;
                op_r    <= 1'b0;
                wdata_r <= dp_wdata;
            end else if (grant_dp_s) begin
                owner_r <= OWN_DP;
                op_r    <= dp_op;
                wdata_r <= dp_wdata;
            end
        end
    end

    // Stack pointer and pop-data return registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_r       <= SP_ZERO;
            dp_rdata_r <= {DATA_LEN{1'b0}};
            pc_rdata_r <= {DATA_LEN{1'b0}};
        end else begin
            if (do_push_s) begin
                sp_r <= sp_r + SP_ONE;
            end else if (do_pop_s) begin
                sp_r <= sp_r - SP_ONE;
            end
            // Empty pops return zero through pop_data_s.
            if (exec_s && !op_r) begin
                if (owner_r == OWN_PC) begin
                    pc_rdata_r <= pop_data_s;
                end else begin
                    dp_rdata_r <= pop_data_s;
                end
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (err_clr) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (err_clr) begin
                unf_r <= 1'b0;
            end
        end
    end

    // Stack storage; not reset, unreachable entries are hidden by sp.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[sp_r[AW-1:0]] <= wdata_r;
        end
    end

    assign dp_gnt   = dp_gnt_r;
    assign pc_gnt   = pc_gnt_r;
    assign dp_valid = dp_valid_r;
    assign pc_valid = pc_valid_r;
    assign dp_rdata = dp_rdata_r;
    assign pc_rdata = pc_rdata_r;
    assign sp       = sp_r;
    assign empty    = empty_s;
    assign full     = full_s;
    assign ovf_err  = ovf_r;
    assign unf_err  = unf_r;

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
//   Table of single transactions with constant expectations, hand-written
//   sequences for arbitration, overflow, empty pop and reset-in-EXEC, then a
//   randomized run against a queue-based stack model.
// -----------------------------------------------------------------------------
module tb_stack_arbiter;

    localparam int DL    = 8;
    localparam int DEPTH = 16;
    localparam int SPW   = 5;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           dp_req = 1'b0;
    logic           dp_op = 1'b0;
    logic [DL-1:0]  dp_wdata = 8'h00;
    logic           dp_gnt, dp_valid, pc_gnt, pc_valid;
    logic [DL-1:0]  dp_rdata, pc_rdata;
    logic           pc_req = 1'b0;
    logic           err_clr = 1'b0;
    logic [SPW-1:0] sp;
    logic           empty, full, ovf_err, unf_err;

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_LEN(DL), .STK_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .dp_req(dp_req), .dp_op(dp_op), .dp_wdata(dp_wdata),
        .dp_gnt(dp_gnt), .dp_valid(dp_valid), .dp_rdata(dp_rdata),
        .pc_req(pc_req), .pc_gnt(pc_gnt), .pc_valid(pc_valid), .pc_rdata(pc_rdata),
        .err_clr(err_clr), .sp(sp), .empty(empty), .full(full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          use_pc;
        bit          push;
        bit          clr;
        logic [7:0]  wdata;
        logic [7:0]  exp_dp;
        logic [7:0]  exp_pc;
        int          exp_sp;
        bit          exp_ovf;
        bit          exp_unf;
    } vec_t;

    vec_t vecs[8];

    // reference stack model
    logic [7:0] stk[$];
    bit         m_ovf, m_unf;
    logic [7:0] m_dp, m_pc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; dp_req = 1'b0; pc_req = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // One transaction from one requester; checks grant/valid latency and pulse width.
    task automatic do_txn(input bit use_pc, input bit push, input logic [7:0] d);
        int n;
        bit got;
        @(negedge clk);
        if (use_pc) begin
            pc_req = 1'b1;
        end else begin
            dp_req = 1'b1; dp_op = push; dp_wdata = d;
        end
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            got = use_pc ? pc_gnt : dp_gnt;
        end
        check("gnt_latency", n, 1);
        // scramble after grant: the DUT must use the values latched at grant
        dp_wdata = ~d; dp_op = ~push;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            got = use_pc ? pc_valid : dp_valid;
        end
        check("valid_latency", n, 2);
        pc_req = 1'b0; dp_req = 1'b0;
        @(negedge clk);
        check("valid_pulse", use_pc ? pc_valid : dp_valid, 0);
    endtask

    // Both requesters raised in the same cycle; DP may push or pop.
    task automatic both_txn(input bit dp_push, input logic [7:0] d, input bit exp_pc_first);
        int pg, pv, dg, dv;
        pg = 0; pv = 0; dg = 0; dv = 0;
        @(negedge clk);
        pc_req = 1'b1; dp_req = 1'b1; dp_op = dp_push; dp_wdata = d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pc_gnt && pg == 0) pg = k;
            if (dp_gnt && dg == 0) dg = k;
            if (pc_valid && pv == 0) begin pv = k; pc_req = 1'b0; end
            if (dp_valid && dv == 0) begin dv = k; dp_req = 1'b0; end
            if (pv != 0 && dv != 0) break;
        end
        pc_req = 1'b0; dp_req = 1'b0;
        check("rr_pc_gnt",   pg, exp_pc_first ? 1 : 4);
        check("rr_pc_valid", pv, exp_pc_first ? 3 : 6);
        check("rr_dp_gnt",   dg, exp_pc_first ? 4 : 1);
        check("rr_dp_valid", dv, exp_pc_first ? 6 : 3);
    endtask

    task automatic model_txn(input bit use_pc, input bit push, input logic [7:0] d);
        logic [7:0] v;
        if (!use_pc && push) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            if (stk.size() > 0) v = stk.pop_back();
            else begin v = 8'h00; m_unf = 1'b1; end
            if (use_pc) m_pc = v; else m_dp = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int        n;
        bit        seen;
        bit        use_pc, push, clr;
        logic [7:0] d;

        //            pc  push clr wdata  exp_dp exp_pc sp ovf unf
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 8'h00, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 8'h00, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h33, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h22, 8'h33, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 8'h33, 0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 8'h00, 0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h5A, 8'h11, 8'h00, 1, 1'b0, 1'b0};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_sp", sp, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_gnt_valid", {dp_gnt, pc_gnt, dp_valid, pc_valid}, 0);
        check("rst_rdata", {dp_rdata, pc_rdata}, 0);
        check("rst_err", {ovf_err, unf_err}, 0);
        rstn = 1'b1;

        // table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr) pulse_clr();
            do_txn(vecs[i].use_pc, vecs[i].push, vecs[i].wdata);
            check("vec_sp", sp, vecs[i].exp_sp);
            check("vec_dp_rdata", dp_rdata, vecs[i].exp_dp);
            check("vec_pc_rdata", pc_rdata, vecs[i].exp_pc);
            check("vec_ovf", ovf_err, vecs[i].exp_ovf);
            check("vec_unf", unf_err, vecs[i].exp_unf);
            check("vec_empty", empty, (vecs[i].exp_sp == 0) ? 1 : 0);
        end

        // simultaneous requests, last owner DP -> PC first (pops 5A), then DP pushes 44
        both_txn(1'b1, 8'h44, 1'b1);
        check("rr1_sp", sp, 1);
        check("rr1_pc_rdata", pc_rdata, 8'h5A);
        // PC pops 44, making PC the last owner
        do_txn(1'b1, 1'b0, 8'h00);
        check("rr_pop_pc_rdata", pc_rdata, 8'h44);
        // last owner PC -> DP first (pushes 66), then PC pops 66
        both_txn(1'b1, 8'h66, 1'b0);
        check("rr2_sp", sp, 0);
        check("rr2_pc_rdata", pc_rdata, 8'h66);
        check("rr2_unf", unf_err, 0);

        // fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 1'b1, 8'h80 + 8'(i));
        check("fill_full", full, 1);
        check("fill_sp", sp, DEPTH);
        do_txn(1'b0, 1'b1, 8'hEE);
        check("ovf_sp", sp, DEPTH);
        check("ovf_flag", ovf_err, 1);
        check("ovf_unf", unf_err, 0);
        pulse_clr();
        check("ovf_clr", ovf_err, 0);
        do_txn(1'b0, 1'b0, 8'h00);
        check("ovf_top_intact", dp_rdata, 8'h8F);
        check("ovf_pop_sp", sp, DEPTH - 1);

        // empty-stack PC pop
        do_reset();
        do_txn(1'b1, 1'b0, 8'h00);
        check("empty_pop_rdata", pc_rdata, 0);
        check("empty_pop_sp", sp, 0);
        check("empty_pop_unf", unf_err, 1);

        // reset asserted while a push is in EXEC at sp = 5
        do_reset();
        for (int i = 0; i < 5; i++) do_txn(1'b0, 1'b1, 8'hA0 + 8'(i));
        check("pre_abort_sp", sp, 5);
        @(negedge clk);
        dp_req = 1'b1; dp_op = 1'b1; dp_wdata = 8'hAB;
        @(negedge clk);
        check("abort_gnt", dp_gnt, 1);
        rstn = 1'b0; dp_req = 1'b0;
        @(negedge clk);
        check("abort_sp", sp, 0);
        rstn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dp_valid || pc_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        do_txn(1'b0, 1'b0, 8'h00);
        check("abort_pop_unf", unf_err, 1);
        check("abort_pop_rdata", dp_rdata, 0);

        // randomized run against the queue model
        do_reset();
        stk.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dp = 8'h00; m_pc = 8'h00;
        for (int i = 0; i < 200; i++) begin
            use_pc = ($urandom_range(0, 3) == 0);
            n      = (i < 100) ? 75 : 30;
            push   = ($urandom_range(0, 99) < n);
            d      = 8'($urandom);
            clr    = ($urandom_range(0, 14) == 0);
            if (clr) begin
                pulse_clr();
                m_ovf = 1'b0; m_unf = 1'b0;
            end
            do_txn(use_pc, push, d);
            model_txn(use_pc, push, d);
            check("rnd_sp", sp, stk.size());
            check("rnd_dp_rdata", dp_rdata, m_dp);
            check("rnd_pc_rdata", pc_rdata, m_pc);
            check("rnd_ovf", ovf_err, m_ovf);
            check("rnd_unf", unf_err, m_unf);
            check("rnd_full", full, (stk.size() == DEPTH) ? 1 : 0);
            check("rnd_empty", empty, (stk.size() == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
